// File: rtl/gg_deblock_wr_pkg.sv
// Shared types, offsets and helpers for the deblocking-filter frame-store writer.
package gg_deblock_wr_pkg;
   localparam int unsigned PIX_W   = 8;
   localparam int unsigned BLK_PIX = 16;
   localparam int unsigned COORD_W = 11;
   localparam int unsigned POS_W   = 10;
   localparam int unsigned N_SRC   = 4;

   typedef logic [0:BLK_PIX-1][PIX_W-1:0] blk_t;

   typedef struct packed {
      logic [1:0]       plane;
      logic [POS_W-1:0] bx;
      logic [POS_W-1:0] by;
      blk_t             data;
   } wr_entry_t;

   // Slot order ale, abv, lef, cur (bit 0 = ale); a set bit means offset -1 on that axis.
   localparam logic [N_SRC-1:0] OFS_DX_NEG = 4'b0101;
   localparam logic [N_SRC-1:0] OFS_DY_NEG = 4'b0011;

   function automatic logic [1:0] cidx_to_plane(input logic [2:0] cidx);
      case (cidx)
         3'd2:    return 2'd1;
         3'd3:    return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic cidx_active(input logic [2:0] cidx);
      return (cidx <= 3'd3);
   endfunction
endpackage

// File: rtl/gg_deblock_writer_if.sv
// Filtered-block input and frame-store write port of the deblocking writer.
interface gg_deblock_writer_if;
   import gg_deblock_wr_pkg::*;

   logic [7:0]       mb_width;
   logic [7:0]       mb_height;
   logic [7:0]       mbx;
   logic [7:0]       mby;
   logic [2:0]       cidx;
   logic [3:0]       bidx;
   logic             ale_valid;
   logic             abv_valid;
   logic             lef_valid;
   logic             cur_valid;
   blk_t             ale_filt;
   blk_t             abv_filt;
   blk_t             lef_filt;
   blk_t             cur_filt;
   logic             wr_valid;
   logic             wr_ready;
   logic [1:0]       wr_plane;
   logic [POS_W-1:0] wr_bx;
   logic [POS_W-1:0] wr_by;
   blk_t             wr_data;
   logic             almost_full;
   logic             overflow;
   logic             addr_err;
   logic             clr_err;
   logic             frame_done;

   modport master (
      output mb_width, mb_height, mbx, mby, cidx, bidx,
      output ale_valid, abv_valid, lef_valid, cur_valid,
      output ale_filt, abv_filt, lef_filt, cur_filt,
      output wr_ready, clr_err,
      input  wr_valid, wr_plane, wr_bx, wr_by, wr_data,
      input  almost_full, overflow, addr_err, frame_done
   );

   modport slave (
      input  mb_width, mb_height, mbx, mby, cidx, bidx,
      input  ale_valid, abv_valid, lef_valid, cur_valid,
      input  ale_filt, abv_filt, lef_filt, cur_filt,
      input  wr_ready, clr_err,
      output wr_valid, wr_plane, wr_bx, wr_by, wr_data,
      output almost_full, overflow, addr_err, frame_done
   );
endinterface

// File: rtl/gg_deblock_wr_fifo.sv
// Show-ahead FIFO accepting up to N_IN packed pushes and one pop per cycle;
// pushes beyond free space are dropped last-slot-first and flagged as overflow.
module gg_deblock_wr_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AFULL = 8,
   parameter int unsigned N_IN  = 4,
   parameter type         T     = logic [7:0]
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_IN-1:0] i_push,
   input  T                i_data [N_IN],
   input  logic            i_pop_ready,
   input  logic            i_clr_err,
   output logic            o_valid,
   output T                o_head,
   output logic            o_almost_full,
   output logic            o_overflow
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned RNK_W = $clog2(N_IN + 1);

   T                 r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_valid;
   logic             r_afull;
   logic             r_overflow;

   logic             w_pop;
   logic             w_drop;
   logic [CNT_W-1:0] w_free;
   logic [CNT_W-1:0] w_count_nxt;
   logic [N_IN-1:0]  w_acc;
   logic [RNK_W-1:0] w_k;
   logic [PTR_W-1:0] w_addr [N_IN];

   assign w_pop  = r_valid & i_pop_ready;
   assign w_free = CNT_W'(DEPTH) - r_count + CNT_W'(w_pop);

   // Accepted slots are packed in slot order; once free space runs out the rest drop.
   always_comb begin
      logic [RNK_W-1:0] v_rank;
      v_rank = '0;
      w_drop = 1'b0;
      w_acc  = '0;
      for (int i = 0; i < int'(N_IN); i++) begin
         w_addr[i] = r_wr_ptr + PTR_W'(v_rank);
         w_acc[i]  = i_push[i] && (CNT_W'(v_rank) < w_free);
         w_drop    = w_drop | (i_push[i] & ~w_acc[i]);
         if (w_acc[i]) v_rank = v_rank + RNK_W'(1);
      end
      w_k = v_rank;
   end

   assign w_count_nxt = r_count + CNT_W'(w_k) - CNT_W'(w_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_valid    <= 1'b0;
         r_afull    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_wr_ptr   <= r_wr_ptr + PTR_W'(w_k);
         r_rd_ptr   <= r_rd_ptr + PTR_W'(w_pop);
         r_count    <= w_count_nxt;
         r_valid    <= (w_count_nxt != '0);
         r_afull    <= (w_count_nxt >= CNT_W'(AFULL));
         r_overflow <= (r_overflow & ~i_clr_err) | w_drop;
      end
   end

   // Storage needs no reset: the head is masked until an entry is written.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(N_IN); i++) begin
         if (w_acc[i]) r_mem[w_addr[i]] <= i_data[i];
      end
   end

   assign o_valid       = r_valid;
   assign o_head        = r_valid ? r_mem[r_rd_ptr] : '0;
   assign o_almost_full = r_afull;
   assign o_overflow    = r_overflow;
endmodule

// File: rtl/gg_deblock_writer.sv
// Turns up to four filtered neighbour blocks per cycle into absolute-coordinate
// frame-store writes, one per cycle, with frame completion detection.
module gg_deblock_writer
   import gg_deblock_wr_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AFULL = 8
) (
   input logic                 clk,
   input logic                 reset,
   gg_deblock_writer_if.slave  if_bus
);
   logic [N_SRC-1:0]   w_flag;
   logic [N_SRC-1:0]   w_neg;
   logic [N_SRC-1:0]   w_push;
   logic [COORD_W-1:0] w_base_x;
   logic [COORD_W-1:0] w_base_y;
   logic [COORD_W-1:0] w_bx [N_SRC];
   logic [COORD_W-1:0] w_by [N_SRC];
   logic [1:0]         w_plane;
   blk_t               w_blk [N_SRC];
   wr_entry_t          w_ent [N_SRC];
   wr_entry_t          w_head;
   logic               w_head_valid;
   logic               w_afull;
   logic               w_overflow;
   logic               w_pop;
   logic               w_last;
   logic               r_addr_err;
   logic               r_frame_done;

   assign w_flag = {if_bus.cur_valid, if_bus.lef_valid, if_bus.abv_valid, if_bus.ale_valid}
                   & {N_SRC{cidx_active(if_bus.cidx)}};
   assign w_blk[0] = if_bus.ale_filt;
   assign w_blk[1] = if_bus.abv_filt;
   assign w_blk[2] = if_bus.lef_filt;
   assign w_blk[3] = if_bus.cur_filt;
   assign w_plane  = cidx_to_plane(if_bus.cidx);

   // Scaling by 4 (luma) or 2 (chroma) plus the local offset is a plain concatenation.
   always_comb begin
      if (if_bus.cidx[2:1] == 2'b00) begin
         w_base_x = COORD_W'({if_bus.mbx, if_bus.bidx[2], if_bus.bidx[0]});
         w_base_y = COORD_W'({if_bus.mby, if_bus.bidx[3], if_bus.bidx[1]});
      end else begin
         w_base_x = COORD_W'({if_bus.mbx, if_bus.bidx[0]});
         w_base_y = COORD_W'({if_bus.mby, if_bus.bidx[1]});
      end
      for (int i = 0; i < int'(N_SRC); i++) begin
         w_bx[i]   = w_base_x - COORD_W'(OFS_DX_NEG[i]);
         w_by[i]   = w_base_y - COORD_W'(OFS_DY_NEG[i]);
         w_neg[i]  = w_flag[i] & (w_bx[i][COORD_W-1] | w_by[i][COORD_W-1]);
         w_push[i] = w_flag[i] & ~w_neg[i];
         w_ent[i]  = '{plane: w_plane,
                       bx:    w_bx[i][POS_W-1:0],
                       by:    w_by[i][POS_W-1:0],
                       data:  w_blk[i]};
      end
   end

   gg_deblock_wr_fifo #(
      .DEPTH (DEPTH),
      .AFULL (AFULL),
      .N_IN  (N_SRC),
      .T     (wr_entry_t)
   ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .i_push        (w_push),
      .i_data        (w_ent),
      .i_pop_ready   (if_bus.wr_ready),
      .i_clr_err     (if_bus.clr_err),
      .o_valid       (w_head_valid),
      .o_head        (w_head),
      .o_almost_full (w_afull),
      .o_overflow    (w_overflow)
   );

   assign w_pop  = w_head_valid & if_bus.wr_ready;
   assign w_last = (w_head.plane == 2'd2)
                 && (w_head.bx == POS_W'({if_bus.mb_width, 1'b1}))
                 && (w_head.by == POS_W'({if_bus.mb_height, 1'b1}));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr_err   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_addr_err   <= (r_addr_err & ~if_bus.clr_err) | (|w_neg);
         r_frame_done <= w_pop & w_last;
      end
   end

   assign if_bus.wr_valid    = w_head_valid;
   assign if_bus.wr_plane    = w_head.plane;
   assign if_bus.wr_bx       = w_head.bx;
   assign if_bus.wr_by       = w_head.by;
   assign if_bus.wr_data     = w_head.data;
   assign if_bus.almost_full = w_afull;
   assign if_bus.overflow    = w_overflow;
   assign if_bus.addr_err    = r_addr_err;
   assign if_bus.frame_done  = r_frame_done;
endmodule

// File: tb/tb_gg_deblock_writer.sv
// Directed bench for gg_deblock_writer: coordinates, ordering, errors,
// buffer limits, frame completion and mid-frame reset.
module tb_gg_deblock_writer;
   import gg_deblock_wr_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;

   gg_deblock_writer_if bus ();

   gg_deblock_writer #(.DEPTH(16), .AFULL(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .if_bus (bus)
   );

   always #5 clk = ~clk;

   function automatic blk_t make_blk(input logic [7:0] seed);
      blk_t b;
      for (int j = 0; j < 16; j++) b[j] = seed + 8'(j * 7);
      return b;
   endfunction

   function automatic logic [149:0] got_entry();
      return {bus.wr_plane, bus.wr_bx, bus.wr_by, bus.wr_data};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_flags();
      bus.ale_valid = 1'b0;
      bus.abv_valid = 1'b0;
      bus.lef_valid = 1'b0;
      bus.cur_valid = 1'b0;
      bus.clr_err   = 1'b0;
   endtask

   task automatic set_flags(input logic [3:0] f);
      {bus.cur_valid, bus.lef_valid, bus.abv_valid, bus.ale_valid} = f;
   endtask

   task automatic set_pos(input logic [2:0] c, input logic [3:0] b, input logic [7:0] x, input logic [7:0] y);
      bus.cidx = c;
      bus.bidx = b;
      bus.mbx  = x;
      bus.mby  = y;
   endtask

   task automatic load_blocks(input logic [7:0] base);
      bus.ale_filt = make_blk(base);
      bus.abv_filt = make_blk(base + 8'd1);
      bus.lef_filt = make_blk(base + 8'd2);
      bus.cur_filt = make_blk(base + 8'd3);
   endtask

   // Fill the 16-entry buffer with four full pushes at luma mbx=1,mby=1,bidx=15.
   task automatic fill_four(input logic [7:0] base0);
      bus.wr_ready = 1'b0;
      set_pos(3'd0, 4'd15, 8'd1, 8'd1);
      for (int p = 0; p < 4; p++) begin
         load_blocks(base0 + 8'(p * 16));
         set_flags(4'hF);
         tick();
      end
      clear_flags();
   endtask

   task automatic test_reset();
      clear_flags();
      bus.wr_ready  = 1'b1;
      bus.mb_width  = 8'd10;
      bus.mb_height = 8'd10;
      set_pos(3'd0, 4'd0, 8'd0, 8'd0);
      load_blocks(8'h00);
      reset = 1'b0;
      tick();
      tick();
      checks++;
      if ({bus.wr_valid, bus.almost_full, bus.overflow, bus.addr_err, bus.frame_done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 00000",
                  {bus.wr_valid, bus.almost_full, bus.overflow, bus.addr_err, bus.frame_done});
      end
      checks++;
      if (got_entry() !== 150'd0) begin
         errors++;
         $display("FAIL reset_wr_bus: got %h want 0", got_entry());
      end
      reset = 1'b1;
      tick();
      checks++;
      if (bus.wr_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_valid: got %b want 0", bus.wr_valid);
      end
   endtask

   task automatic test_luma_four();
      logic [149:0] exp_e [4];
      // mbx=1,mby=2,bidx=3 -> local (1,1), current block (5,9).
      exp_e[0] = {2'd0, 10'd4, 10'd8, make_blk(8'h10)};
      exp_e[1] = {2'd0, 10'd5, 10'd8, make_blk(8'h11)};
      exp_e[2] = {2'd0, 10'd4, 10'd9, make_blk(8'h12)};
      exp_e[3] = {2'd0, 10'd5, 10'd9, make_blk(8'h13)};
      bus.wr_ready = 1'b1;
      set_pos(3'd0, 4'd3, 8'd1, 8'd2);
      load_blocks(8'h10);
      set_flags(4'hF);
      tick();
      clear_flags();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({bus.wr_valid, got_entry()} !== {1'b1, exp_e[k]}) begin
            errors++;
            $display("FAIL luma_write%0d: got v=%b %h want v=1 %h", k, bus.wr_valid, got_entry(), exp_e[k]);
         end
         tick();
      end
      checks++;
      if (bus.wr_valid !== 1'b0) begin
         errors++;
         $display("FAIL luma_drained: got %b want 0", bus.wr_valid);
      end
   endtask

   task automatic test_addr_err();
      bus.wr_ready = 1'b1;
      set_pos(3'd0, 4'd0, 8'd0, 8'd0);
      set_flags(4'b0100);
      tick();
      clear_flags();
      checks++;
      if ({bus.wr_valid, bus.addr_err} !== 2'b01) begin
         errors++;
         $display("FAIL addr_drop: got valid=%b err=%b want valid=0 err=1", bus.wr_valid, bus.addr_err);
      end
      tick();
      checks++;
      if (bus.addr_err !== 1'b1) begin
         errors++;
         $display("FAIL addr_sticky: got %b want 1", bus.addr_err);
      end
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      checks++;
      if (bus.addr_err !== 1'b0) begin
         errors++;
         $display("FAIL addr_clear: got %b want 0", bus.addr_err);
      end
      set_pos(3'd5, 4'd0, 8'd0, 8'd0);
      set_flags(4'hF);
      tick();
      clear_flags();
      checks++;
      if ({bus.wr_valid, bus.addr_err} !== 2'b00) begin
         errors++;
         $display("FAIL cidx_ignored: got valid=%b err=%b want 0 0", bus.wr_valid, bus.addr_err);
      end
      set_pos(3'd0, 4'd0, 8'd0, 8'd0);
      set_flags(4'b0100);
      bus.clr_err = 1'b1;
      tick();
      clear_flags();
      checks++;
      if (bus.addr_err !== 1'b1) begin
         errors++;
         $display("FAIL addr_set_wins: got %b want 1", bus.addr_err);
      end
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
   endtask

   task automatic test_overflow();
      int exp_bx [4] = '{6, 7, 6, 7};
      int exp_by [4] = '{6, 6, 7, 7};
      logic [149:0] exp_v;
      bus.wr_ready = 1'b0;
      set_pos(3'd0, 4'd15, 8'd1, 8'd1);
      for (int p = 0; p < 4; p++) begin
         load_blocks(8'h80 + 8'(p * 16));
         set_flags(4'hF);
         tick();
         checks++;
         if (bus.almost_full !== (((p + 1) * 4) >= 8)) begin
            errors++;
            $display("FAIL ovf_afull_push%0d: got %b want %b", p, bus.almost_full, ((p + 1) * 4) >= 8);
         end
      end
      checks++;
      if (bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_full_no_ovf: got %b want 0", bus.overflow);
      end
      load_blocks(8'hF0);
      set_flags(4'hF);
      tick();
      clear_flags();
      exp_v = {2'd0, 10'd6, 10'd6, make_blk(8'h80)};
      checks++;
      if ({bus.overflow, bus.wr_valid, got_entry()} !== {2'b11, exp_v}) begin
         errors++;
         $display("FAIL ovf_fifth_push: got ovf=%b v=%b %h want ovf=1 v=1 %h",
                  bus.overflow, bus.wr_valid, got_entry(), exp_v);
      end
      bus.wr_ready = 1'b1;
      for (int n = 0; n < 16; n++) begin
         exp_v = {2'd0, 10'(exp_bx[n % 4]), 10'(exp_by[n % 4]), make_blk(8'h80 + 8'((n / 4) * 16 + (n % 4)))};
         checks++;
         if ({bus.wr_valid, bus.almost_full, got_entry()} !== {1'b1, (16 - n) >= 8, exp_v}) begin
            errors++;
            $display("FAIL ovf_drain%0d: got v=%b af=%b %h want v=1 af=%b %h",
                     n, bus.wr_valid, bus.almost_full, got_entry(), (16 - n) >= 8, exp_v);
         end
         tick();
      end
      checks++;
      if ({bus.wr_valid, bus.almost_full, bus.overflow} !== 3'b001) begin
         errors++;
         $display("FAIL ovf_after_drain: got v/af/ovf=%b want 001",
                  {bus.wr_valid, bus.almost_full, bus.overflow});
      end
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      checks++;
      if (bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: got %b want 0", bus.overflow);
      end
   endtask

   task automatic test_push_pop_full();
      int exp_bx [4] = '{6, 7, 6, 7};
      int exp_by [4] = '{6, 6, 7, 7};
      logic [149:0] exp_v;
      fill_four(8'h00);
      bus.wr_ready = 1'b1;
      bus.cur_filt = make_blk(8'hC0);
      set_flags(4'b1000);
      tick();
      clear_flags();
      checks++;
      if ({bus.overflow, bus.almost_full, bus.wr_valid} !== 3'b011) begin
         errors++;
         $display("FAIL full_pushpop_flags: got ovf/af/v=%b want 011",
                  {bus.overflow, bus.almost_full, bus.wr_valid});
      end
      for (int n = 1; n <= 16; n++) begin
         if (n < 16)
            exp_v = {2'd0, 10'(exp_bx[n % 4]), 10'(exp_by[n % 4]), make_blk(8'((n / 4) * 16 + (n % 4)))};
         else
            exp_v = {2'd0, 10'd7, 10'd7, make_blk(8'hC0)};
         checks++;
         if ({bus.wr_valid, got_entry()} !== {1'b1, exp_v}) begin
            errors++;
            $display("FAIL full_pushpop_drain%0d: got v=%b %h want v=1 %h", n, bus.wr_valid, got_entry(), exp_v);
         end
         tick();
      end
      checks++;
      if (bus.wr_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_pushpop_empty: got %b want 0", bus.wr_valid);
      end
   endtask

   task automatic test_frame_done();
      logic [149:0] exp_v;
      bus.wr_ready  = 1'b1;
      bus.mb_width  = 8'd2;
      bus.mb_height = 8'd2;
      bus.cur_filt  = make_blk(8'h55);
      set_pos(3'd2, 4'd3, 8'd2, 8'd2);
      set_flags(4'b1000);
      tick();
      clear_flags();
      exp_v = {2'd1, 10'd5, 10'd5, make_blk(8'h55)};
      checks++;
      if ({bus.wr_valid, got_entry()} !== {1'b1, exp_v}) begin
         errors++;
         $display("FAIL fd_cb_write: got v=%b %h want v=1 %h", bus.wr_valid, got_entry(), exp_v);
      end
      tick();
      checks++;
      if (bus.frame_done !== 1'b0) begin
         errors++;
         $display("FAIL fd_cb_no_pulse: got %b want 0", bus.frame_done);
      end
      set_pos(3'd3, 4'd3, 8'd2, 8'd2);
      set_flags(4'b1000);
      tick();
      clear_flags();
      exp_v = {2'd2, 10'd5, 10'd5, make_blk(8'h55)};
      checks++;
      if ({bus.wr_valid, bus.frame_done, got_entry()} !== {2'b10, exp_v}) begin
         errors++;
         $display("FAIL fd_cr_write: got v=%b fd=%b %h want v=1 fd=0 %h",
                  bus.wr_valid, bus.frame_done, got_entry(), exp_v);
      end
      tick();
      checks++;
      if ({bus.frame_done, bus.wr_valid} !== 2'b10) begin
         errors++;
         $display("FAIL fd_pulse: got fd=%b v=%b want fd=1 v=0", bus.frame_done, bus.wr_valid);
      end
      tick();
      checks++;
      if (bus.frame_done !== 1'b0) begin
         errors++;
         $display("FAIL fd_one_cycle: got %b want 0", bus.frame_done);
      end
      bus.mb_width  = 8'd10;
      bus.mb_height = 8'd10;
   endtask

   task automatic test_reset_mid();
      logic [149:0] exp_v;
      bus.wr_ready = 1'b0;
      set_pos(3'd0, 4'd15, 8'd1, 8'd1);
      load_blocks(8'h40);
      set_flags(4'hF);
      tick();
      set_flags(4'b1000);
      tick();
      clear_flags();
      checks++;
      if (bus.wr_valid !== 1'b1) begin
         errors++;
         $display("FAIL rmid_buffered: got %b want 1", bus.wr_valid);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.wr_valid, got_entry()} !== 151'd0) begin
         errors++;
         $display("FAIL rmid_async: got v=%b %h want all 0", bus.wr_valid, got_entry());
      end
      tick();
      reset = 1'b1;
      bus.wr_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (bus.wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_stale%0d: got %b want 0", c, bus.wr_valid);
         end
      end
      bus.cur_filt = make_blk(8'h99);
      set_flags(4'b1000);
      tick();
      clear_flags();
      exp_v = {2'd0, 10'd7, 10'd7, make_blk(8'h99)};
      checks++;
      if ({bus.wr_valid, got_entry()} !== {1'b1, exp_v}) begin
         errors++;
         $display("FAIL rmid_fresh: got v=%b %h want v=1 %h", bus.wr_valid, got_entry(), exp_v);
      end
      tick();
      checks++;
      if (bus.wr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rmid_fresh_only: got %b want 0", bus.wr_valid);
      end
   endtask

   initial begin
      test_reset();
      test_luma_four();
      test_addr_err();
      test_overflow();
      test_push_pop_full();
      test_frame_done();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
